// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU package: hazard controller state encodings, MDU latency default
// and boot sequence length.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MDU_BUSY = 2'd2
    } hz_state_e;

    localparam int MDU_LAT_DEFAULT = 32;
    localparam int BOOT_LEN        = 2;

    localparam int CNT_W      = 8;
    localparam int BOOT_CNT_W = 2;
    localparam int REG_W      = 5;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// register an EX-stage load is about to write.
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic             i_mem_read,
    input  logic             i_reg_write,
    input  logic [REG_W-1:0] i_rt_idex,
    input  logic [REG_W-1:0] i_rs_ifid,
    input  logic [REG_W-1:0] i_rt_ifid,
    input  logic             i_uses_rs,
    input  logic             i_uses_rt,
    output logic             o_hazard
);

    logic [REG_W-1:0] w_src [2];
    logic [1:0]       w_use;
    logic [1:0]       w_match;
    logic             w_load_live;

    assign w_src[0] = i_rs_ifid;
    assign w_src[1] = i_rt_ifid;
    assign w_use    = {i_uses_rt, i_uses_rs};

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign w_load_live = i_mem_read && i_reg_write && (i_rt_idex != '0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign w_match[gi] = w_use[gi] && (w_src[gi] == i_rt_idex);
        end
    endgenerate

    assign o_hazard = w_load_live && (|w_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: boot flush sequence, MDU busy tracking,
// prioritised stall/flush generation and a front-end stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs_IFID,
    input  logic [REG_W-1:0] Rt_IFID,
    input  logic             UsesRs_ID,
    input  logic             UsesRt_ID,
    input  logic             UsesHILO_ID,
    input  logic             MemRead_IDEX,
    input  logic             RegWrite_IDEX,
    input  logic [REG_W-1:0] Rt_IDEX,
    input  logic             MDUOp_IDEX,
    input  logic             BranchTaken_EX,
    input  logic             MemBusy,
    output logic             PC_Stall,
    output logic             IFID_Stall,
    output logic             IFID_Flush,
    output logic             ID_Stall,
    output logic             ID_Flush,
    output logic             MDUBusy,
    output logic [31:0]      StallCycles
);

    hz_state_e             r_state;
    hz_state_e             w_state_next;
    logic [BOOT_CNT_W-1:0] r_boot_cnt;
    logic [BOOT_CNT_W-1:0] w_boot_cnt_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [31:0]           r_stall_cnt;
    logic [31:0]           w_stall_cnt_next;

    logic w_load_use;
    logic w_mdu_hazard;

    load_use_detect u_load_use_detect (
        .i_mem_read  (MemRead_IDEX),
        .i_reg_write (RegWrite_IDEX),
        .i_rt_idex   (Rt_IDEX),
        .i_rs_ifid   (Rs_IFID),
        .i_rt_ifid   (Rt_IFID),
        .i_uses_rs   (UsesRs_ID),
        .i_uses_rt   (UsesRt_ID),
        .o_hazard    (w_load_use)
    );

    assign w_mdu_hazard = (r_state == ST_MDU_BUSY) && UsesHILO_ID;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= '0;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_boot_cnt  <= w_boot_cnt_next;
            r_cnt       <= w_cnt_next;
            r_stall_cnt <= w_stall_cnt_next;
        end
    end

    // Next-state: MDU entry ignores MemBusy/branch; busy countdown never pauses.
    always_comb begin
        w_state_next    = r_state;
        w_boot_cnt_next = r_boot_cnt;
        w_cnt_next      = r_cnt;
        case (r_state)
            ST_BOOT: begin
                if (r_boot_cnt == BOOT_CNT_W'(BOOT_LEN - 1)) begin
                    w_state_next    = ST_RUN;
                    w_boot_cnt_next = '0;
                end else begin
                    w_boot_cnt_next = r_boot_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (MDUOp_IDEX) begin
                    w_state_next = ST_MDU_BUSY;
                    w_cnt_next   = CNT_W'(MDU_LAT);
                end
            end
            ST_MDU_BUSY: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next    = ST_BOOT;
                w_boot_cnt_next = '0;
                w_cnt_next      = '0;
            end
        endcase
    end

    always_comb begin
        PC_Stall   = 1'b0;
        IFID_Stall = 1'b0;
        IFID_Flush = 1'b0;
        ID_Stall   = 1'b0;
        ID_Flush   = 1'b0;
        if (rst || (r_state != ST_RUN && r_state != ST_MDU_BUSY)) begin
            IFID_Flush = 1'b1;
            ID_Flush   = 1'b1;
        end else if (MemBusy) begin
            PC_Stall   = 1'b1;
            IFID_Stall = 1'b1;
            ID_Stall   = 1'b1;
        end else if (BranchTaken_EX) begin
            IFID_Flush = 1'b1;
            ID_Flush   = 1'b1;
        end else if (w_mdu_hazard || w_load_use) begin
            // Hold fetch and ID, inject a bubble into EX.
            PC_Stall   = 1'b1;
            IFID_Stall = 1'b1;
            ID_Flush   = 1'b1;
        end
    end

    always_comb begin
        w_stall_cnt_next = r_stall_cnt;
        if (PC_Stall && (r_state != ST_BOOT) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            w_stall_cnt_next = r_stall_cnt + 32'd1;
        end
    end

    assign MDUBusy     = (r_state == ST_MDU_BUSY) && !rst;
    assign StallCycles = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 32, SHALL set the multiply/divide busy duration in cycles (legal range 2..255).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 Rs_IFID, Rt_IFID  input  5 each  source register fields of the instruction in ID.
REQ-005 UsesRs_ID, UsesRt_ID  input  1 each  the ID instruction actually reads Rs / Rt.
REQ-006 UsesHILO_ID  input  1  the ID instruction reads HI/LO or is itself an MDU op.
REQ-007 MemRead_IDEX, RegWrite_IDEX  input  1 each  the EX-stage instruction is a load / writes a register.
REQ-008 Rt_IDEX  input  5  destination register of the EX-stage load.
REQ-009 MDUOp_IDEX  input  1  an MDU op occupies EX this cycle.
REQ-010 BranchTaken_EX  input  1  a branch or jump resolved taken in EX.
REQ-011 MemBusy  input  1  data memory wait request.
REQ-012 PC_Stall, IFID_Stall, IFID_Flush, ID_Stall, ID_Flush  output  1 each  stage controls; ID_Stall and ID_Flush drive the ID/EX register.
REQ-013 MDUBusy  output  1  MDU busy indication.
REQ-014 StallCycles  output  32  performance counter of front-end stall cycles.

Function
REQ-015 States: BOOT, RUN, MDU_BUSY. Stage outputs SHALL be combinational from the current state and current inputs (zero-cycle latency).
REQ-016 BOOT SHALL last exactly 2 cycles after rst deasserts. In BOOT: IFID_Flush=1, ID_Flush=1, all stalls=0, all other inputs ignored. BOOT SHALL then go to RUN.
REQ-017 Priority in RUN and MDU_BUSY, highest first: MemBusy, BranchTaken_EX, MDU hazard, load-use hazard.
REQ-018 MemBusy=1: PC_Stall, IFID_Stall and ID_Stall SHALL be 1; both flushes SHALL be 0.
REQ-019 BranchTaken_EX=1 with MemBusy=0: IFID_Flush=1, ID_Flush=1, all stalls=0.
REQ-020 MDU hazard = state MDU_BUSY and UsesHILO_ID=1. Response: PC_Stall=1, IFID_Stall=1, ID_Flush=1 (bubble), ID_Stall=0, IFID_Flush=0.
REQ-021 Load-use hazard = MemRead_IDEX and RegWrite_IDEX and Rt_IDEX!=0 and ((UsesRs_ID and Rs_IFID==Rt_IDEX) or (UsesRt_ID and Rt_IFID==Rt_IDEX)). Response: same as REQ-020.
REQ-022 With no hazard, no branch and no MemBusy, all five stage outputs SHALL be 0.
REQ-023 RUN with MDUOp_IDEX=1 SHALL move to MDU_BUSY and load cnt=MDU_LAT. This holds regardless of MemBusy and BranchTaken_EX.
REQ-024 In MDU_BUSY, cnt SHALL decrement every cycle, including MemBusy cycles. When cnt==1, the state SHALL return to RUN. MDUBusy=1 for exactly MDU_LAT cycles.
REQ-025 MDUOp_IDEX while in MDU_BUSY SHALL be ignored: no reload, no extension.
REQ-026 StallCycles SHALL increment by 1 on each cycle with PC_Stall=1 outside BOOT. It SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-027 rst=1 SHALL force state=BOOT with boot count 0, cnt=0 and StallCycles=0. This SHALL take effect on the next edge from any state, including mid-MDU_BUSY.
REQ-028 While rst=1: IFID_Flush=1, ID_Flush=1, all stalls=0, MDUBusy=0.

Structure
REQ-029 State encodings, the MDU_LAT default and the boot length (2) SHALL live in the shared CPU package.
REQ-030 Load-use comparison SHALL be one combinational sub-module, load_use_detect. FSM, counters and priority muxing SHALL stay in hazard_ctrl.

Verification
REQ-031 Reset, then idle inputs -> flushes high for exactly 2 cycles after rst falls, then all stage outputs 0 and StallCycles=0.
REQ-032 Load-use: MemRead_IDEX=1, RegWrite_IDEX=1, Rt_IDEX=5, Rs_IFID=5, UsesRs_ID=1 for one cycle -> PC_Stall=1, IFID_Stall=1, ID_Flush=1, ID_Stall=0, StallCycles=1. Repeat with Rt_IDEX=0 -> no stall.
REQ-033 MDU: MDUOp_IDEX pulse with MDU_LAT=32, UsesHILO_ID=1 held -> MDUBusy and the front-end stall high for 32 cycles, then low; StallCycles=32.
REQ-034 Simultaneous BranchTaken_EX=1 and load-use hazard -> IFID_Flush=1, ID_Flush=1, no stalls. Add MemBusy=1 -> stalls=1, flushes=0.
REQ-035 rst asserted at MDU cycle 10 -> MDUBusy=0 next cycle; BOOT repeats; cnt and StallCycles are 0.
REQ-036 Force StallCycles to 32'hFFFFFFFE, then 3 stall cycles -> value holds at 32'hFFFFFFFF.
